uart_dec_rx: RTL and testbench
==============================

Name: uart_dec_rx

Overview:
- Receive-side counterpart of the team's decimal UART transmitter. It deserialises 8N1 UART bytes from uart_rxd and parses ASCII decimal digit strings terminated by CR (0x0D) into a 16-bit unsigned value.
- It presents each parsed value with a single-cycle valid pulse. Malformed lines produce an error pulse instead.
- Intended use: host-to-FPGA configuration values, such as steering angle and gain, on the acoustic camera.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 115200, line rate. BIT_CNT = CLK_FREQ/BAUD, integer division.
- MAX_DIGITS, 5, maximum digits accepted per line.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset: asynchronous, active-low. Clock is sys_clk.
- uart_rxd  input  1  serial line; idle high; asynchronous to sys_clk.
- data_out  output  16  last successfully parsed value; held until the next success.
- data_valid  output  1  one-cycle pulse; data_out is updated in the same cycle.
- data_err  output  1  one-cycle pulse on a rejected line.
- busy  output  1  high while a line is partially received (digit count > 0, or in DISCARD).

Behaviour:
- Reset values: data_out=0, data_valid=0, data_err=0, busy=0. Synchroniser flops reset to 1. All counters and the accumulator reset to 0. Parser and bit receiver go to IDLE.
- Synchroniser: uart_rxd passes through 2 flops. All logic uses the synchronised copy.
- Bit receiver FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge (sync 1->0) moves to START. The baud counter clears.
  - START: at BIT_CNT/2 cycles, sample the line. Low goes to DATA. High is a glitch and returns to IDLE with no byte.
  - DATA: sample every BIT_CNT cycles. 8 bits, LSB first, shifted into an 8-bit register.
  - STOP: sample after BIT_CNT cycles. High gives a byte_valid pulse (1 cycle) with the byte. Low gives a frame_err pulse and the byte is dropped. Both return to IDLE immediately; no wait for the end of the stop bit.
- Parser FSM (IDLE, ACCUM, DISCARD). It acts only on byte_valid or frame_err cycles.
  - '0'..'9' (0x30..0x39): acc_next = acc*10 + (byte-0x30), computed in 17 bits; cnt++; IDLE moves to ACCUM.
  - Overflow: if acc_next > 65535, or cnt would exceed MAX_DIGITS, go to DISCARD.
  - CR in ACCUM: data_out <= acc[15:0], data_valid=1 on the following cycle, then IDLE with acc and cnt cleared.
  - CR in IDLE (empty line): ignored. No pulse.
  - CR in DISCARD: data_err=1 on the following cycle, then IDLE. data_out is unchanged.
  - LF (0x0A): ignored in all states, so CRLF works.
  - Any other byte, or frame_err, in IDLE or ACCUM: go to DISCARD.
  - In DISCARD, everything except CR is ignored.
- Latency: data_valid and data_err rise exactly 1 cycle after the byte_valid of the terminating CR.
- Leading zeros are accepted: "00042" = 42. This matches the transmitter's fixed 5-digit format.
- Back-to-back bytes with zero idle time are handled. The next start edge is detected right after stop-bit sampling.
- Reset mid-byte or mid-line: everything is cleared. After release, a line in progress is mis-parsed at most once, then re-synchronises on the next CR.
- data_valid and data_err are never high in the same cycle.

Decomposition:
- Package uart_pkg: ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_9=8'h39; bit-receiver and parser state encodings.
- Sub-module uart_rx: the bit receiver (synchroniser plus bit FSM). Outputs rx_byte[7:0], byte_valid, frame_err. It mirrors the existing uart_tx and is reusable.
- uart_dec_rx contains the parser and instantiates uart_rx.

Test Plan:
- Send "00042\r" at BAUD -> one data_valid pulse, data_out=16'd42, busy low afterwards, data_err never high.
- Send "65535\r" then "65536\r" -> first: data_valid, data_out=65535. Second: data_err pulse, data_out stays 65535.
- Send "12a4\r", then "123456\r" -> data_err pulse for each, no data_valid. Then "7\r\n8\r" -> data_valid twice with data_out=7 then 8, and LF produces no pulse.
- Drive a lone "\r", and a 0.3-bit low glitch on uart_rxd -> no data_valid, no data_err, no byte_valid.
- Send '5' with stop bit forced low, then "3\r" -> frame_err gives DISCARD, CR gives data_err. A following "3\r" gives data_out=3.
- Assert sys_rst_n low mid-byte of "123\r" -> all outputs 0 immediately. After release, "9\r" gives data_out=9. Also loop the team's uart_tx formatter into uart_rxd with values 0, 1, 12345, 65535 -> each value is recovered exactly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the decimal UART receive path.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_ACCUM,
    PS_DISCARD
  } ps_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_dec_rx_if.sv
// Parsed-value output bundle of the decimal UART receiver.
interface uart_dec_rx_if;

  logic [15:0] data_out;
  logic        data_valid;
  logic        data_err;
  logic        busy;

  modport master (output data_out, data_valid, data_err, busy);
  modport slave  (input  data_out, data_valid, data_err, busy);

endinterface

// File: rtl/uart_rx.sv
// 8N1 bit receiver: two-flop synchroniser, start-edge detect, mid-bit sampling.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | counting to mid start bit; high there is a glitch
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling the stop bit; high = byte, low = framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(BIT_CNT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          tc;

  assign tc = (baud_q == '0);

  always_comb begin
    state_d      = state_q;
    sync1_d      = uart_rxd;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          baud_d  = HALF_LD;
        end
      end
      RX_START: begin
        if (tc) begin
          if (!sync2_q) begin
            state_d = RX_DATA;
            baud_d  = FULL_LD;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (tc) begin
          shift_d = {sync2_q, shift_q[7:1]};
          baud_d  = FULL_LD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      RX_STOP: begin
        // Return to IDLE right at mid stop bit so a back-to-back start edge is caught.
        if (tc) begin
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_q;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = RX_IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= RX_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      rx_byte_q    <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_dec_rx.sv
// Decimal line parser: ASCII digits terminated by CR become a 16-bit value.
//
// state      | meaning
// PS_IDLE    | no digits received on the current line
// PS_ACCUM   | accumulating digits into acc
// PS_DISCARD | line rejected; waiting for CR to report the error
module uart_dec_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int MAX_DIGITS = 5
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          uart_rxd,
  uart_dec_rx_if.master dec
);

  localparam int CNTW = $clog2(MAX_DIGITS + 2);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  ps_state_t       state_q, state_d;
  logic [15:0]     acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [15:0]     data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            data_err_q, data_err_d;
  logic            busy_q, busy_d;
  logic [16:0]     acc_next;

  // Digit count is capped, so acc never exceeds 9999 before the last legal digit.
  assign acc_next = ({1'b0, acc_q} * 17'd10) + 17'(rx_byte - ASCII_0);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_err_d   = 1'b0;

    if (byte_valid) begin
      if (rx_byte == ASCII_LF) begin
        state_d = state_q;
      end else if (rx_byte == ASCII_CR) begin
        if (state_q == PS_ACCUM) begin
          data_out_d   = acc_q;
          data_valid_d = 1'b1;
        end else if (state_q == PS_DISCARD) begin
          data_err_d   = 1'b1;
        end
        state_d = PS_IDLE;
        acc_d   = 16'd0;
        cnt_d   = '0;
      end else if (state_q != PS_DISCARD) begin
        if (is_digit(rx_byte) && (acc_next <= 17'd65535) &&
            (cnt_q < CNTW'(MAX_DIGITS))) begin
          state_d = PS_ACCUM;
          acc_d   = acc_next[15:0];
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = PS_DISCARD;
          acc_d   = 16'd0;
          cnt_d   = '0;
        end
      end
    end else if (frame_err) begin
      state_d = PS_DISCARD;
      acc_d   = 16'd0;
      cnt_d   = '0;
    end

    busy_d = (state_d != PS_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= PS_IDLE;
      acc_q        <= 16'd0;
      cnt_q        <= '0;
      data_out_q   <= 16'd0;
      data_valid_q <= 1'b0;
      data_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_err_q   <= data_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dec.data_out   = data_out_q;
  assign dec.data_valid = data_valid_q;
  assign dec.data_err   = data_err_q;
  assign dec.busy       = busy_q;

endmodule

// File: tb/tb_uart_dec_rx.sv
// Scoreboard bench for uart_dec_rx: directed lines in, expected pulses queued, monitor compares.
module tb_uart_dec_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int BIT_CNT  = CLK_FREQ / BAUD;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd  = 1'b1;

  uart_dec_rx_if dif ();

  uart_dec_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .MAX_DIGITS (5)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .dec       (dif)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && (dif.data_valid || dif.data_err)) begin
        check("valid_err_overlap", {31'd0, dif.data_valid & dif.data_err}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: valid=%0d err=%0d data_out=%0d (t=%0t)",
                   dif.data_valid, dif.data_err, dif.data_out, $time);
        end else begin
          e = sb.pop_front();
          check("pulse_is_err", {31'd0, dif.data_err}, {31'd0, e.is_err});
          check("data_out", {16'd0, dif.data_out}, {16'd0, e.val});
        end
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_bits(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    uart_rxd = 1'b0;
    wait_bits(BIT_CNT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_bits(BIT_CNT);
    end
    uart_rxd = stop_ok;
    wait_bits(BIT_CNT);
    uart_rxd = 1'b1;
    if (!stop_ok) wait_bits(BIT_CNT);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Same framing as the transmitter: five zero-padded digits, then CR LF.
  task automatic send_tx_fmt(input int v);
    send_str($sformatf("%05d", v));
    send_byte(8'h0D);
    send_byte(8'h0A);
  endtask

  task automatic exp_ok(input logic [15:0] v);
    sb.push_back('{is_err: 1'b0, val: v});
  endtask

  task automatic exp_err(input logic [15:0] held);
    sb.push_back('{is_err: 1'b1, val: held});
  endtask

  task automatic settle(input string name);
    wait_bits(2 * BIT_CNT);
    check({name, "_pending"}, sb.size(), 32'd0);
    check({name, "_busy"}, {31'd0, dif.busy}, 32'd0);
  endtask

  initial begin
    int vals[4] = '{0, 1, 12345, 65535};

    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    wait_bits(3);
    check("rst_data_out", {16'd0, dif.data_out}, 32'd0);
    check("rst_valid", {31'd0, dif.data_valid}, 32'd0);
    check("rst_err", {31'd0, dif.data_err}, 32'd0);
    check("rst_busy", {31'd0, dif.busy}, 32'd0);
    sys_rst_n = 1'b1;
    wait_bits(5);

    exp_ok(16'd42);
    send_str("000");
    check("busy_mid_line", {31'd0, dif.busy}, 32'd1);
    send_str("42\015");
    settle("t42");

    exp_ok(16'd65535);
    send_str("65535\015");
    exp_err(16'd65535);
    send_str("65536\015");
    settle("t65536");
    check("hold_after_overflow", {16'd0, dif.data_out}, 32'd65535);

    exp_err(16'd65535);
    send_str("12a4\015");
    exp_err(16'd65535);
    send_str("123456\015");
    exp_ok(16'd7);
    exp_ok(16'd8);
    send_str("7\015\0128\015");
    settle("tbad_then_78");

    send_str("\015");
    settle("tlone_cr");
    uart_rxd = 1'b0;
    wait_bits((BIT_CNT * 3) / 10);
    uart_rxd = 1'b1;
    wait_bits(2 * BIT_CNT);
    settle("tglitch");
    exp_ok(16'd4);
    send_str("4\015");
    settle("tafter_glitch");

    send_byte("5", 1'b0);
    exp_err(16'd4);
    send_str("3\015");
    exp_ok(16'd3);
    send_str("3\015");
    settle("tframe");

    send_str("12");
    check("busy_before_reset", {31'd0, dif.busy}, 32'd1);
    uart_rxd = 1'b0;
    wait_bits(BIT_CNT);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = (8'h33 >> i) & 1'b1;
      wait_bits(BIT_CNT);
    end
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst_data_out", {16'd0, dif.data_out}, 32'd0);
    check("midrst_valid", {31'd0, dif.data_valid}, 32'd0);
    check("midrst_err", {31'd0, dif.data_err}, 32'd0);
    check("midrst_busy", {31'd0, dif.busy}, 32'd0);
    uart_rxd = 1'b1;
    wait_bits(3);
    sys_rst_n = 1'b1;
    wait_bits(2 * BIT_CNT);
    exp_ok(16'd9);
    send_str("9\015");
    settle("tafter_reset");

    foreach (vals[k]) begin
      exp_ok(vals[k][15:0]);
      send_tx_fmt(vals[k]);
      settle($sformatf("tloop_%0d", vals[k]));
      check($sformatf("loop_value_%0d", vals[k]), {16'd0, dif.data_out}, vals[k]);
    end

    wait_bits(4 * BIT_CNT);
    check("sb_empty_end", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
